rvv_backend_retire_byte_merge: RTL and testbench
================================================

RVV_BACKEND_RETIRE_BYTE_MERGE -- requirements
Module: rvv_backend_retire_byte_merge

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered uop entries (legal values 2 or 4).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  trap flush; discards all buffered uops.
REQ-005 SHALL have port uop_valid  input  1  result uop offered.
REQ-006 SHALL have port uop_ready  output  1  result uop accepted when uop_valid && uop_ready.
REQ-007 SHALL have port uop_data  input  `VLEN  execution result, byte i at [8i+7:8i].
REQ-008 SHALL have port uop_byte_type  input  `VLENB x BYTE_TYPE_t  per-byte vd type (NOT_CHANGE, BODY_ACTIVE, BODY_INACTIVE, TAIL).
REQ-009 SHALL have port uop_vd_addr  input  5  destination register.
REQ-010 SHALL have port uop_vma / uop_vta  input  1 each  mask-agnostic / tail-agnostic policy bits.
REQ-011 SHALL have port uop_last  input  1  final uop of the instruction.
REQ-012 SHALL have port wr_valid  output  1  VRF write offered.
REQ-013 SHALL have port wr_ready  input  1  VRF accepts write.
REQ-014 SHALL have ports wr_addr (5), wr_data (`VLEN), wr_strobe (`VLENB), wr_last (1)  outputs  write payload.
REQ-015 SHALL have ports instr_done (1) and instr_uop_cnt (4)  outputs  one-cycle completion pulse and uops written for that instruction.

Function
REQ-016 Merge SHALL be computed at enqueue; stored entry holds merged data, strobe, addr, last.
REQ-017 BODY_ACTIVE byte SHALL set strobe=1, data=result byte.
REQ-018 NOT_CHANGE byte SHALL set strobe=0, data=8'h00, regardless of policy bits.
REQ-019 BODY_INACTIVE and TAIL bytes SHALL follow REQ-030/031; any byte with strobe=0 SHALL carry data 8'h00.
REQ-020 Buffer SHALL be an in-order FIFO of DEPTH entries; wr_* SHALL be driven directly from the head-entry registers.
REQ-021 uop_ready SHALL equal (count < DEPTH), registered; accept at cycle N SHALL appear on wr_* no earlier than N+1.
REQ-022 Occupancy states EMPTY, PARTIAL, FULL: push-only increments, pop-only (wr_valid && wr_ready) decrements, push+pop holds count; pointers wrap modulo DEPTH.
REQ-023 wr_valid SHALL be 1 iff count > 0; wr_* payload SHALL be stable while wr_valid && !wr_ready.
REQ-024 A 4-bit uop counter SHALL increment on each pop; on pop with wr_last=1, the cycle after SHALL assert instr_done=1 with instr_uop_cnt = counter+1, and the counter SHALL return to 0.
REQ-025 Counter SHALL saturate at 15 and not wrap.
REQ-026 flush SHALL clear count, pointers and uop counter next cycle; flush overrides simultaneous push/pop; instr_done SHALL NOT pulse for flushed uops.

Reset
REQ-027 On rst: wr_valid=0, wr_addr=0, wr_data=0, wr_strobe=0, wr_last=0, instr_done=0, instr_uop_cnt=0, uop_ready=1 in the first cycle after reset release.
REQ-028 rst mid-transfer SHALL drop all entries without completing the handshake; rst dominates flush.

Configuration
REQ-029 Macro TAIL_AGNOSTIC_ONES_EN SHALL select agnostic fill.
REQ-030 Defined: BODY_INACTIVE with uop_vma=1, and TAIL with uop_vta=1, SHALL set strobe=1, data=8'hFF; with the policy bit 0, strobe=0.
REQ-031 Undefined: BODY_INACTIVE and TAIL SHALL always set strobe=0; uop_vma/uop_vta unused.

Structure
REQ-032 BYTE_TYPE_t, `VLEN, `VLENB SHALL come from the shared rvv_backend package/header; a RETIRE_ENTRY_t struct (data, strobe, addr, last) SHALL be added there.
REQ-033 Per-byte merge SHALL be a combinational sub-module rvv_backend_retire_byte_merge_unit, instantiated once at the FIFO input.

Verification
REQ-034 All bytes BODY_ACTIVE, data 0x0F..00 pattern, addr 3, wr_ready=1 -> next cycle wr_strobe=16'hFFFF, wr_data equal, wr_addr=3.
REQ-035 Bytes 0-3 NOT_CHANGE, 4-11 BODY_ACTIVE, 12-15 TAIL, vta=1 -> strobe=16'h0FF0 without macro; 16'hFFF0 with bytes 12-15=8'hFF with macro.
REQ-036 wr_ready=0, push 3 uops with DEPTH=2 -> uop_ready=0 after second accept, third held; release wr_ready -> order preserved, no loss.
REQ-037 Four uops with last on fourth, wr_ready=1 -> instr_done pulse one cycle after fourth pop, instr_uop_cnt=4.
REQ-038 Two buffered uops, flush asserted with simultaneous uop_valid -> next cycle wr_valid=0, uop_ready=1, no instr_done, new uop not stored.

Source files
------------

// File: rtl/rvv_backend_pkg.sv
// rtl/rvv_backend_pkg.sv - shared RVV backend widths, byte types and retire entry
// Purpose: vector length macros (`VLEN, `VLENB), per-byte vd type, and the
//          merged retire-buffer entry layout shared by the backend blocks.
// Ports:   none (package).
`ifndef VLEN
`define VLEN 128
`endif
`ifndef VLENB
`define VLENB (`VLEN/8)
`endif

package rvv_backend_pkg;

  localparam int VLEN  = `VLEN;
  localparam int VLENB = `VLENB;

  typedef enum logic [1:0] {
    NOT_CHANGE    = 2'd0,
    BODY_ACTIVE   = 2'd1,
    BODY_INACTIVE = 2'd2,
    TAIL          = 2'd3
  } BYTE_TYPE_t;

  // One buffered write: data/strobe already merged at enqueue time.
  typedef struct packed {
    logic [VLEN-1:0]  data;
    logic [VLENB-1:0] strobe;
    logic [4:0]       addr;
    logic             last;
  } RETIRE_ENTRY_t;

endpackage

// File: rtl/rvv_backend_retire_byte_merge_unit.sv
// rtl/rvv_backend_retire_byte_merge_unit.sv - combinational per-byte vd merge
// Purpose: turns a result vector plus per-byte types into write data/strobe.
//          TAIL_AGNOSTIC_ONES_EN: agnostic inactive/tail bytes are written as 8'hFF.
// Ports:   data/byte_type/vma/vta in; merged_data/merged_strobe out.
module rvv_backend_retire_byte_merge_unit
  import rvv_backend_pkg::*;
(
  input  logic [VLEN-1:0]         data,
  input  BYTE_TYPE_t [VLENB-1:0]  byte_type,
  input  logic                    vma,
  input  logic                    vta,
  output logic [VLEN-1:0]         merged_data,
  output logic [VLENB-1:0]        merged_strobe
);

  // Bytes not written always carry 8'h00, so only strobed bytes get data.
  always_comb begin
    merged_data   = '0;
    merged_strobe = '0;
    for (int i = 0; i < VLENB; i++) begin
      case (byte_type[i])
        BODY_ACTIVE: begin
          merged_strobe[i]     = 1'b1;
          merged_data[8*i +: 8] = data[8*i +: 8];
        end
`ifdef TAIL_AGNOSTIC_ONES_EN
        BODY_INACTIVE: begin
          if (vma) begin
            merged_strobe[i]     = 1'b1;
            merged_data[8*i +: 8] = 8'hFF;
          end
        end
        TAIL: begin
          if (vta) begin
            merged_strobe[i]     = 1'b1;
            merged_data[8*i +: 8] = 8'hFF;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef TAIL_AGNOSTIC_ONES_EN
  // Undisturbed-only build: policy bits have no effect.
  logic unused_policy;
  assign unused_policy = vma ^ vta;
`endif

endmodule

// File: rtl/rvv_backend_retire_byte_merge.sv
// rtl/rvv_backend_retire_byte_merge.sv - retire byte merge and in-order VRF write buffer
// Purpose: merges each result uop at enqueue, buffers DEPTH entries in order,
//          issues VRF writes from the head entry and reports instruction completion.
//          TAIL_AGNOSTIC_ONES_EN selects all-ones fill for agnostic bytes.
// Ports:   clk/rst/flush; uop_* result input (valid/ready); wr_* VRF write
//          output (valid/ready); instr_done/instr_uop_cnt completion pulse.
module rvv_backend_retire_byte_merge
  import rvv_backend_pkg::*;
#(
  parameter int DEPTH = 2
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   uop_valid,
  output logic                   uop_ready,
  input  logic [VLEN-1:0]        uop_data,
  input  BYTE_TYPE_t [VLENB-1:0] uop_byte_type,
  input  logic [4:0]             uop_vd_addr,
  input  logic                   uop_vma,
  input  logic                   uop_vta,
  input  logic                   uop_last,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [4:0]             wr_addr,
  output logic [VLEN-1:0]        wr_data,
  output logic [VLENB-1:0]       wr_strobe,
  output logic                   wr_last,
  output logic                   instr_done,
  output logic [3:0]             instr_uop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  RETIRE_ENTRY_t    mem [DEPTH];
  RETIRE_ENTRY_t    enq_entry;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [3:0]       uop_cnt;
  logic [3:0]       uop_cnt_inc;
  logic             push;
  logic             pop;

  rvv_backend_retire_byte_merge_unit u_merge (
    .data          (uop_data),
    .byte_type     (uop_byte_type),
    .vma           (uop_vma),
    .vta           (uop_vta),
    .merged_data   (enq_entry.data),
    .merged_strobe (enq_entry.strobe)
  );

  assign enq_entry.addr = uop_vd_addr;
  assign enq_entry.last = uop_last;

  assign push = uop_valid && uop_ready;
  assign pop  = wr_valid && wr_ready;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Head entry registers drive the write port directly.
  assign wr_valid  = (count != '0);
  assign wr_addr   = mem[rd_ptr].addr;
  assign wr_data   = mem[rd_ptr].data;
  assign wr_strobe = mem[rd_ptr].strobe;
  assign wr_last   = mem[rd_ptr].last;

  assign uop_cnt_inc = (uop_cnt == 4'd15) ? 4'd15 : uop_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      uop_cnt       <= '0;
      uop_ready     <= 1'b1;
      instr_done    <= 1'b0;
      instr_uop_cnt <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      uop_cnt    <= '0;
      uop_ready  <= 1'b1;
      instr_done <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enq_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      uop_ready  <= (count_next < DEPTH_C);
      instr_done <= pop && wr_last;
      if (pop) begin
        if (wr_last) begin
          instr_uop_cnt <= uop_cnt_inc;
          uop_cnt       <= '0;
        end else begin
          uop_cnt <= uop_cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvv_backend_retire_byte_merge.sv
// tb/tb_rvv_backend_retire_byte_merge.sv - directed self-checking bench for the retire byte merge
module tb_rvv_backend_retire_byte_merge;
  import rvv_backend_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic                   uop_valid;
  logic                   uop_ready;
  logic [VLEN-1:0]        uop_data;
  BYTE_TYPE_t [VLENB-1:0] uop_byte_type;
  logic [4:0]             uop_vd_addr;
  logic                   uop_vma;
  logic                   uop_vta;
  logic                   uop_last;
  logic                   wr_valid;
  logic                   wr_ready;
  logic [4:0]             wr_addr;
  logic [VLEN-1:0]        wr_data;
  logic [VLENB-1:0]       wr_strobe;
  logic                   wr_last;
  logic                   instr_done;
  logic [3:0]             instr_uop_cnt;

  int checks = 0;
  int failures = 0;

  rvv_backend_retire_byte_merge #(.DEPTH(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .uop_valid     (uop_valid),
    .uop_ready     (uop_ready),
    .uop_data      (uop_data),
    .uop_byte_type (uop_byte_type),
    .uop_vd_addr   (uop_vd_addr),
    .uop_vma       (uop_vma),
    .uop_vta       (uop_vta),
    .uop_last      (uop_last),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strobe     (wr_strobe),
    .wr_last       (wr_last),
    .instr_done    (instr_done),
    .instr_uop_cnt (instr_uop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_types(input BYTE_TYPE_t t);
    for (int i = 0; i < VLENB; i++) uop_byte_type[i] = t;
  endtask

  // Offer one uop and return #1 after the edge that accepts it.
  task automatic send(input logic [VLEN-1:0] d, input logic [4:0] a, input logic lst);
    bit ok = 0;
    uop_data    = d;
    uop_vd_addr = a;
    uop_last    = lst;
    uop_valid   = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = (uop_ready === 1'b1);
      tick();
    end
    uop_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout got=0 exp=1");
    end
  endtask

  logic [VLEN-1:0] exp_d;

  initial begin
    rst = 1'b1; flush = 1'b0; uop_valid = 1'b0; uop_data = '0; uop_vd_addr = '0;
    uop_vma = 1'b0; uop_vta = 1'b0; uop_last = 1'b0; wr_ready = 1'b0;
    set_types(BODY_ACTIVE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_wr_valid", VLEN'(wr_valid), '0);
    check("rst_wr_addr", VLEN'(wr_addr), '0);
    check("rst_wr_data", wr_data, '0);
    check("rst_wr_strobe", VLEN'(wr_strobe), '0);
    check("rst_wr_last", VLEN'(wr_last), '0);
    check("rst_instr_done", VLEN'(instr_done), '0);
    check("rst_uop_cnt", VLEN'(instr_uop_cnt), '0);
    check("rst_uop_ready", VLEN'(uop_ready), 1);

    // All bytes active, single-uop instruction
    wr_ready = 1'b1;
    exp_d = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    send(exp_d, 5'd3, 1'b1);
    check("act_wr_valid", VLEN'(wr_valid), 1);
    check("act_strobe", VLEN'(wr_strobe), 16'hFFFF);
    check("act_data", wr_data, exp_d);
    check("act_addr", VLEN'(wr_addr), 3);
    tick();
    check("act_done", VLEN'(instr_done), 1);
    check("act_done_cnt", VLEN'(instr_uop_cnt), 1);
    check("act_drained", VLEN'(wr_valid), 0);

    // NOT_CHANGE / BODY_ACTIVE / TAIL(vta=1)
    for (int i = 0; i < 16; i++)
      uop_byte_type[i] = (i < 4) ? NOT_CHANGE : (i < 12) ? BODY_ACTIVE : TAIL;
    uop_vta = 1'b1;
    send({16{8'hA5}}, 5'd9, 1'b1);
`ifdef TAIL_AGNOSTIC_ONES_EN
    check("mix_strobe", VLEN'(wr_strobe), 16'hFFF0);
    check("mix_data", wr_data, 128'hFFFFFFFF_A5A5A5A5_A5A5A5A5_00000000);
`else
    check("mix_strobe", VLEN'(wr_strobe), 16'h0FF0);
    check("mix_data", wr_data, 128'h00000000_A5A5A5A5_A5A5A5A5_00000000);
`endif
    tick();

    // BODY_INACTIVE(vma=1) / TAIL(vta=0)
    for (int i = 0; i < 16; i++)
      uop_byte_type[i] = (i < 8) ? BODY_INACTIVE : TAIL;
    uop_vma = 1'b1;
    uop_vta = 1'b0;
    send({16{8'h5A}}, 5'd10, 1'b1);
`ifdef TAIL_AGNOSTIC_ONES_EN
    check("inact_strobe", VLEN'(wr_strobe), 16'h00FF);
    check("inact_data", wr_data, 128'h00000000_00000000_FFFFFFFF_FFFFFFFF);
`else
    check("inact_strobe", VLEN'(wr_strobe), 16'h0000);
    check("inact_data", wr_data, '0);
`endif
    tick();
    uop_vma = 1'b0;
    set_types(BODY_ACTIVE);

    // Backpressure: three uops into a two-entry buffer
    wr_ready = 1'b0;
    send({16{8'h11}}, 5'd1, 1'b0);
    check("bp_ready_1", VLEN'(uop_ready), 1);
    send({16{8'h22}}, 5'd2, 1'b0);
    check("bp_ready_full", VLEN'(uop_ready), 0);
    uop_data = {16{8'h33}}; uop_vd_addr = 5'd4; uop_last = 1'b1; uop_valid = 1'b1;
    tick();
    check("bp_head_stable_addr", VLEN'(wr_addr), 1);
    check("bp_head_stable_data", wr_data, {16{8'h11}});
    check("bp_still_full", VLEN'(uop_ready), 0);
    wr_ready = 1'b1;
    tick();
    check("bp_second_addr", VLEN'(wr_addr), 2);
    check("bp_second_data", wr_data, {16{8'h22}});
    tick();
    uop_valid = 1'b0;
    check("bp_third_addr", VLEN'(wr_addr), 4);
    check("bp_third_data", wr_data, {16{8'h33}});
    check("bp_third_last", VLEN'(wr_last), 1);
    tick();
    check("bp_empty", VLEN'(wr_valid), 0);
    check("bp_done", VLEN'(instr_done), 1);
    check("bp_done_cnt", VLEN'(instr_uop_cnt), 3);

    // Four-uop instruction
    send({16{8'h01}}, 5'd5, 1'b0);
    send({16{8'h02}}, 5'd5, 1'b0);
    send({16{8'h03}}, 5'd5, 1'b0);
    send({16{8'h04}}, 5'd5, 1'b1);
    check("four_no_early_done", VLEN'(instr_done), 0);
    tick();
    check("four_done", VLEN'(instr_done), 1);
    check("four_done_cnt", VLEN'(instr_uop_cnt), 4);
    tick();
    check("four_done_pulse", VLEN'(instr_done), 0);

    // Counter saturation
    for (int k = 0; k < 17; k++) send(VLEN'(k), 5'd6, (k == 16));
    tick();
    check("sat_done", VLEN'(instr_done), 1);
    check("sat_cnt", VLEN'(instr_uop_cnt), 15);

    // Flush with two buffered uops and a simultaneous offer
    wr_ready = 1'b0;
    send({16{8'h77}}, 5'd7, 1'b0);
    send({16{8'h88}}, 5'd8, 1'b1);
    flush = 1'b1; uop_valid = 1'b1; uop_data = {16{8'h99}}; uop_last = 1'b1;
    tick();
    flush = 1'b0; uop_valid = 1'b0;
    check("flush_wr_valid", VLEN'(wr_valid), 0);
    check("flush_uop_ready", VLEN'(uop_ready), 1);
    check("flush_no_done", VLEN'(instr_done), 0);
    wr_ready = 1'b1;
    tick();
    check("flush_nothing_stored", VLEN'(wr_valid), 0);
    check("flush_no_done_later", VLEN'(instr_done), 0);

    // Flush with one buffered uop while ready: offer dropped
    wr_ready = 1'b0;
    send({16{8'hAB}}, 5'd11, 1'b0);
    flush = 1'b1; uop_valid = 1'b1; uop_data = {16{8'hCD}};
    tick();
    flush = 1'b0; uop_valid = 1'b0;
    tick();
    check("flush1_not_stored", VLEN'(wr_valid), 0);

    // Flush clears the uop counter
    wr_ready = 1'b1;
    send({16{8'h12}}, 5'd12, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    send({16{8'h13}}, 5'd13, 1'b1);
    tick();
    check("flush_cnt_done", VLEN'(instr_done), 1);
    check("flush_cnt_cleared", VLEN'(instr_uop_cnt), 1);

    // Reset mid-transfer, asserted with flush
    wr_ready = 1'b0;
    send({16{8'hEE}}, 5'd14, 1'b1);
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0;
    check("mrst_wr_valid", VLEN'(wr_valid), 0);
    check("mrst_wr_addr", VLEN'(wr_addr), 0);
    check("mrst_wr_data", wr_data, '0);
    check("mrst_uop_ready", VLEN'(uop_ready), 1);
    check("mrst_instr_done", VLEN'(instr_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
